// File: rtl/split_struct_ctrl_pkg.sv
// Shared definitions for the split-struct write sequencer.
// Field selects, FSM encodings and the assembled word layout.
package split_struct_ctrl_pkg;

   localparam int FIELD_W_DEF = 2;

   localparam logic SEL_FIRST = 1'b0;
   localparam logic SEL_LAST  = 1'b1;

   localparam logic [0:0] ST_COLLECT = 1'b0;
   localparam logic [0:0] ST_PUBLISH = 1'b1;

   typedef struct packed {
      logic [FIELD_W_DEF-1:0] last;
      logic [FIELD_W_DEF-1:0] first;
   } split_word_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// rr_ptr names the requester that wins a tie.
module rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] grant
);

   logic rr_ptr;

   always_comb begin
      grant = 2'b00;
      if (enable && !reset) begin
         unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   // After serving requester 0 the other one is favoured, and vice versa.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr <= 1'b0;
      end else if (|grant) begin
         rr_ptr <= grant[0];
      end
   end

endmodule

// File: rtl/split_struct_ctrl.sv
// Collects {last, first} field writes from two requesters and
// publishes the assembled word on a valid/ready output.
module split_struct_ctrl
   import split_struct_ctrl_pkg::*;
#(
   parameter int FIELD_W = FIELD_W_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           req_valid,
   input  logic [1:0]           req_sel,
   input  logic [2*FIELD_W-1:0] req_data,
   output logic [1:0]           req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*FIELD_W-1:0] out_data,
   output logic [1:0]           pending
);

   logic [0:0]           state;
   logic [2*FIELD_W-1:0] s;
   logic                 wr_first;
   logic                 wr_last;
   logic [1:0]           grant;
   logic                 g_sel;
   logic [FIELD_W-1:0]   g_data;
   logic [1:0]           nxt_flags;
   logic                 arb_en;

   assign arb_en = (state == ST_COLLECT);

   rr_arb2 u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    (req_valid),
      .enable (arb_en),
      .grant  (grant)
   );

   always_comb begin
      g_sel     = grant[1] ? req_sel[1] : req_sel[0];
      g_data    = grant[1] ? req_data[2*FIELD_W-1:FIELD_W]
                           : req_data[FIELD_W-1:0];
      nxt_flags = {wr_last, wr_first};
      if (|grant) begin
         if (g_sel == SEL_LAST) nxt_flags[1] = 1'b1;
         else                   nxt_flags[0] = 1'b1;
      end
   end

   // s is deliberately kept across a publish; only the flags clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_COLLECT;
         s        <= '0;
         wr_first <= 1'b0;
         wr_last  <= 1'b0;
      end else begin
         unique case (state)
            ST_COLLECT: begin
               if (|grant) begin
                  if (g_sel == SEL_LAST)
                     s[2*FIELD_W-1:FIELD_W] <= g_data;
                  else
                     s[FIELD_W-1:0] <= g_data;
                  wr_first <= nxt_flags[0];
                  wr_last  <= nxt_flags[1];
                  if (&nxt_flags) state <= ST_PUBLISH;
               end
            end
            ST_PUBLISH: begin
               if (out_ready) begin
                  wr_first <= 1'b0;
                  wr_last  <= 1'b0;
                  state    <= ST_COLLECT;
               end
            end
            default: state <= ST_COLLECT;
         endcase
      end
   end

   assign req_ready = grant;
   assign out_valid = (state == ST_PUBLISH);
   assign out_data  = s;
   assign pending   = {wr_last, wr_first};

endmodule

// File: tb/tb_split_struct_ctrl.sv
// Self-checking bench for split_struct_ctrl: directed scenarios
// plus a randomized run against a behavioural model.
module tb_split_struct_ctrl;

   localparam int FW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_sel = '0;
   logic [2*FW-1:0] req_data = '0;
   logic [1:0]    req_ready;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [2*FW-1:0] out_data;
   logic [1:0]    pending;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [FW-1:0] m_first, m_last;
   logic [1:0]    m_flags;
   bit            m_pub;
   int            m_fav;
   logic [1:0]    e_grant;

   split_struct_ctrl #(.FIELD_W(FW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .pending   (pending)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] sel,
                        input logic [3:0] d, input logic ordy);
      req_valid = v;
      req_sel   = sel;
      req_data  = d;
      out_ready = ordy;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(2'b00, 2'b00, 4'h0, 1'b0);
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(2'b11, 2'b10, 4'hF, 1'b1);
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL reset_grant: got %b want 00", req_ready);
      end
      tick();
      tick();
      reset = 1'b0;
      drive(2'b00, 2'b00, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || pending !== 2'b00 ||
             out_data !== 4'h0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: ov=%b pend=%b od=%h rr=%b want 0/00/0/00",
                     out_valid, pending, out_data, req_ready);
         end
      end
   endtask

   task automatic test_basic();
      do_reset();
      drive(2'b01, 2'b00, 4'b0001, 1'b1);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL basic_g0: got %b want 01", req_ready);
      end
      tick();
      checks++;
      if (pending !== 2'b01 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_pend1: pend=%b ov=%b want 01/0", pending, out_valid);
      end
      drive(2'b10, 2'b10, 4'b1000, 1'b1);
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL basic_g1: got %b want 10", req_ready);
      end
      tick();
      drive(2'b00, 2'b00, 4'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'b1001 || pending !== 2'b11) begin
         errors++;
         $display("FAIL basic_pub: ov=%b od=%b pend=%b want 1/1001/11",
                  out_valid, out_data, pending);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || pending !== 2'b00 || out_data !== 4'b1001) begin
         errors++;
         $display("FAIL basic_done: ov=%b pend=%b od=%b want 0/00/1001",
                  out_valid, pending, out_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
      do_reset();
      drive(2'b11, 2'b10, 4'b0011, 1'b1);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (req_ready !== exp_g[i]) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: got %b want %b", i, req_ready, exp_g[i]);
         end
         if (exp_g[i] == 2'b00) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'b0011) begin
               errors++;
               $display("FAIL b2b_pub[%0d]: ov=%b od=%b want 1/0011",
                        i, out_valid, out_data);
            end
         end
         tick();
      end
   endtask

   task automatic test_overwrite();
      do_reset();
      drive(2'b01, 2'b00, 4'b0001, 1'b1);
      tick();
      drive(2'b01, 2'b00, 4'b0010, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b0 || pending !== 2'b01) begin
         errors++;
         $display("FAIL ovw_nopub: ov=%b pend=%b want 0/01", out_valid, pending);
      end
      drive(2'b10, 2'b10, 4'b0100, 1'b1);
      tick();
      drive(2'b00, 2'b00, 4'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'b0110) begin
         errors++;
         $display("FAIL ovw_pub: ov=%b od=%b want 1/0110", out_valid, out_data);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovw_once: ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive(2'b11, 2'b10, 4'b1101, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 4'b1101 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL stall[%0d]: ov=%b od=%b rr=%b want 1/1101/00",
                     i, out_valid, out_data, req_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b00 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_hs: rr=%b ov=%b want 00/1", req_ready, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 2'b01) begin
         errors++;
         $display("FAIL stall_rel: ov=%b rr=%b want 0/01", out_valid, req_ready);
      end
   endtask

   task automatic test_reset_publish();
      do_reset();
      drive(2'b10, 2'b10, 4'b1000, 1'b0);
      tick();
      drive(2'b01, 2'b00, 4'b0001, 1'b0);
      tick();
      drive(2'b00, 2'b00, 4'h0, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rstpub_enter: ov=%b want 1", out_valid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(2'b11, 2'b10, 4'b0110, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || pending !== 2'b00 || req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rstpub: ov=%b pend=%b rr=%b want 0/00/01",
                  out_valid, pending, req_ready);
      end
   endtask

   task automatic model_reset();
      m_first = '0;
      m_last  = '0;
      m_flags = 2'b00;
      m_pub   = 0;
      m_fav   = 0;
   endtask

   task automatic test_random();
      int n_pub = 0;
      int who;
      logic [FW-1:0] d;
      do_reset();
      model_reset();
      req_valid = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         reset = ($urandom_range(0, 49) == 0);
         for (int r = 0; r < 2; r++) begin
            if (!req_valid[r] && $urandom_range(0, 2) != 0) begin
               req_valid[r] = 1'b1;
               req_sel[r]   = 1'($urandom_range(0, 1));
               req_data[r*FW +: FW] = FW'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         // expected grant from the arbitration rules
         e_grant = 2'b00;
         if (!reset && !m_pub) begin
            if (req_valid == 2'b11) e_grant = (m_fav == 0) ? 2'b01 : 2'b10;
            else                    e_grant = req_valid;
         end
         checks++;
         if (req_ready !== e_grant || out_valid !== logic'(m_pub) ||
             pending !== m_flags || out_data !== {m_last, m_first}) begin
            errors++;
            $display("FAIL rand[%0d]: rr=%b/%b ov=%b/%b pend=%b/%b od=%h/%h (got/want)",
                     cyc, req_ready, e_grant, out_valid, m_pub,
                     pending, m_flags, out_data, {m_last, m_first});
         end
         tick();
         if (reset) begin
            model_reset();
         end else if (m_pub) begin
            if (out_ready) begin
               m_pub   = 0;
               m_flags = 2'b00;
               n_pub++;
            end
         end else if (e_grant != 2'b00) begin
            who = e_grant[1] ? 1 : 0;
            d = req_data[who*FW +: FW];
            if (req_sel[who]) begin
               m_last = d;
               m_flags[1] = 1'b1;
            end else begin
               m_first = d;
               m_flags[0] = 1'b1;
            end
            if (m_flags == 2'b11) m_pub = 1;
            m_fav = 1 - who;
         end
         for (int r = 0; r < 2; r++)
            if (e_grant[r]) req_valid[r] = 1'b0;
      end
      reset = 1'b0;
      checks++;
      if (n_pub < 10) begin
         errors++;
         $display("FAIL rand_coverage: publishes %0d want >= 10", n_pub);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_overwrite();
      test_stall();
      test_reset_publish();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/split_struct_ctrl.md
# split_struct_ctrl

Write sequencer for a packed two-field register `{last, first}`. Two independent requesters issue field writes. A round-robin arbiter grants one write per cycle into the shared register. Once both fields have been written since the last publish, the block presents the assembled word on a valid/ready output and stalls further writes until it is consumed. It sits in front of any split-struct register whose halves are produced by different upstream agents.

## Interface
- `FIELD_W`, default 2: width of each field; the assembled word is 2*FIELD_W bits.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  2: per-requester write request; bit i belongs to requester i.
- `req_sel`  in  2: per-requester target field; 0 = `first` (low bits), 1 = `last` (high bits).
- `req_data`  in  2*FIELD_W: requester i's data is at `[i*FIELD_W +: FIELD_W]`.
- `req_ready`  out  2: one-hot grant; bit i high means requester i's write is accepted this cycle.
- `out_valid`  out  1: assembled word available.
- `out_ready`  in  1: consumer accepts the word.
- `out_data`  out  2*FIELD_W: `{last, first}`.
- `pending`  out  2: written-since-publish flags; bit 0 = `first`, bit 1 = `last`.

## Operation
- Registers:
  - `s` (2*FIELD_W).
  - `wr_first`, `wr_last` flags.
  - `rr_ptr` (1 bit): requester favoured on a tie.
  - FSM state.
- FSM states:
  - COLLECT: arbitration is enabled.
  - PUBLISH: `out_valid`=1; `req_ready`=0.
- Arbitration (COLLECT only, combinational):
  - Exactly one requester valid: it is granted.
  - Both valid: `rr_ptr` is granted.
  - Neither valid: no grant.
  - On any grant, `rr_ptr` becomes the other requester's index.
  - `rr_ptr` is unchanged when there is no grant.
- Grant effect at the clock edge:
  - `req_sel`=0 writes `s[FIELD_W-1:0]` and sets `wr_first`.
  - `req_sel`=1 writes `s[2*FIELD_W-1:FIELD_W]` and sets `wr_last`.
  - The untargeted field holds its value.
- Repeated write to an already-flagged field: overwrites the data (last write wins); the flag stays set; no error.
- Transition COLLECT→PUBLISH occurs at the edge where the granted write makes both flags set (the current flags OR the new flag equals 2'b11).
- Transition PUBLISH→COLLECT occurs at the edge where `out_valid && out_ready`. At that edge both flags clear; `s` retains its value (it is not zeroed).
- `out_data` is driven directly from `s`. It is stable throughout PUBLISH.
- `pending` = `{wr_last, wr_first}`.
- Reset values:
  - `s`=0, flags=0, `rr_ptr`=0, state=COLLECT.
  - Outputs: `out_valid`=0, `pending`=0, `out_data`=0.
  - `req_ready` follows the combinational rule (the grant is live in the reset cycle only if `reset` is low).
- `req_ready` is forced to 0 while `reset`=1.

## Timing
- The grant is combinational, in the same cycle as `req_valid`. Requesters must hold `req_sel` and `req_data` stable while `req_valid` is high and unacknowledged.
- Write-to-output latency: if the completing write is granted in cycle N, `out_valid`=1 and `out_data` reflects it in cycle N+1.
- Output handshake: if `out_ready`=1 in the first PUBLISH cycle, `out_valid` drops at N+2. The earliest next grant is also cycle N+2.
- No write is accepted in the same cycle as the output handshake. There is no bypass.
- Throughput: at most one word every 3 cycles (two writes plus one publish cycle).
- Reset asserted mid-PUBLISH: `out_valid`=0 and flags=0 from the next cycle; the word is discarded.
- Reset asserted alongside `req_valid`: no grant; no state change other than the reset values.
- `out_ready` is ignored in COLLECT.

## Structure
- Shared package:
  - `FIELD_W` default.
  - Field-select encodings `SEL_FIRST`=0 and `SEL_LAST`=1.
  - FSM state encodings `ST_COLLECT`=0 and `ST_PUBLISH`=1.
  - The packed struct typedef `{last, first}` used by `out_data` consumers.
- One sub-module, `rr_arb2`: a 2-requester round-robin arbiter holding `rr_ptr`, with inputs `clock`, `reset`, `req[1:0]`, `enable`, and output `grant[1:0]` (one-hot).
- Field write muxing, flags, FSM and the output stage stay in `split_struct_ctrl`.

## Test plan
- Reset, then idle 3 cycles → `out_valid`=0, `pending`=00, `out_data`=4'h0, `req_ready`=00.
- Req0 writes sel=0 data=2'b01, then req1 writes sel=1 data=2'b10, `out_ready`=1 → `pending` goes 01 then 11-transient; `out_valid` in the cycle after the second grant with `out_data`=4'b1001; `out_valid` low one cycle later; `pending`=00.
- Both requesters valid every cycle (req0 sel=0 data=2'b11, req1 sel=1 data=2'b00) from reset → grants alternate 01, 10; output 4'b0011; `req_ready`=00 during PUBLISH.
- Req0 writes `first`=2'b01, then `first`=2'b10, then req1 writes `last`=2'b01 → only one publish, `out_data`=4'b0110.
- Enter PUBLISH with `out_ready`=0 for 5 cycles and requests asserted → `out_valid` and `out_data` held, no grants; raising `out_ready` releases in one cycle.
- Assert `reset` during PUBLISH → next cycle `out_valid`=0, `pending`=00, `rr_ptr`=0 (a tie grants req0 first).
